uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter; fixed at 4 for this revision.
REQ-002 Parameter TIMEOUT, default 16'd12000: clk cycles allowed between tx_start and tx_done before the transfer is abandoned.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 req  input  4  level request per requester; held high until that requester's ack.
REQ-006 req_data  input  32  byte for requester k on bits [8k+7:8k]; held stable while req[k] is high.
REQ-007 tx_done  input  1  one-cycle pulse from the UART transmitter when the stop bit completes.
REQ-008 clr_err  input  1  synchronous clear of timeout_err.
REQ-009 ack  output  4  one-hot; high for exactly one cycle when the requester's byte is accepted.
REQ-010 tx_start  output  1  one-cycle pulse telling the transmitter to send tx_data.
REQ-011 tx_data  output  8  registered byte being transmitted.
REQ-012 owner  output  2  index of the requester currently or last granted.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 timeout_err  output  1  sticky flag indicating a transfer timed out.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, GRANT, START and WAIT.
REQ-016 IDLE with req != 0: the arbiter SHALL choose a winner round-robin, searching from (last_owner+1) mod 4 upward with wrap.
REQ-017 On the IDLE->GRANT edge, owner SHALL load the winner index and tx_data SHALL load that requester's req_data slice.
REQ-018 In GRANT (1 cycle), ack[owner] SHALL be 1 and all other ack bits 0; the next state SHALL be START.
REQ-019 In START (1 cycle), tx_start SHALL be 1 and the timeout counter SHALL be cleared to 0; the next state SHALL be WAIT.
REQ-020 In WAIT, the counter SHALL increment by 1 per cycle (16-bit, no wrap reachable).
- tx_done=1: go to IDLE.
- Otherwise, counter == TIMEOUT-1: go to IDLE and set timeout_err.
- tx_done and timeout in the same cycle: done wins; no error.
REQ-021 Every WAIT->IDLE exit SHALL update last_owner to owner.
REQ-022 tx_done received outside WAIT SHALL be ignored.
REQ-023 Latency: req[k] sampled high in IDLE at edge t SHALL produce ack[k] in cycle t+1 and tx_start in cycle t+2.
REQ-024 Minimum spacing between consecutive tx_start pulses SHALL be 1 (WAIT) + 1 (IDLE) + GRANT + START cycles, i.e. one idle cycle after done.
REQ-025 A req dropped before the IDLE sampling edge SHALL not be granted.
REQ-026 A req still high after its ack SHALL be treated as a new request, ranked behind the other requesters.
REQ-027 If clr_err and a timeout occur in the same cycle, set SHALL win.
REQ-028 tx_data and owner SHALL hold their values outside the IDLE->GRANT edge.
REQ-029 busy SHALL equal (state != IDLE).

Reset
REQ-030 When resetn=0, the block SHALL asynchronously force: state IDLE, owner 0, last_owner 3, tx_data 8'h00, ack 0, tx_start 0, timer 0, timeout_err 0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer with no further tx_start; after release, arbitration SHALL restart with requester 0 as highest priority.

Verification
REQ-032 The bench SHALL cover single request: req=4'b0100, req_data[23:16]=8'hA5, tx_done 50 cycles after tx_start -> ack=4'b0100 at t+1, tx_start at t+2, tx_data=8'hA5, busy returns 0 after tx_done.
REQ-033 The bench SHALL cover all-request fairness: req=4'b1111 held, each req dropped after its ack -> grant order 0,1,2,3; after re-request of 0 and 2 -> order 0,2.
REQ-034 The bench SHALL cover timeout: TIMEOUT=20, no tx_done -> return to IDLE 20 cycles after tx_start; timeout_err=1 until clr_err pulse; next grant proceeds normally.
REQ-035 The bench SHALL cover simultaneous events: tx_done on the exact timeout cycle -> timeout_err stays 0; clr_err coincident with timeout -> timeout_err=1.
REQ-036 The bench SHALL cover reset during WAIT: resetn low for 3 cycles -> all outputs at reset values immediately; a subsequent req=4'b1000 is granted to requester 3 with normal latency.
REQ-037 The bench SHALL cover stray tx_done in IDLE or GRANT -> no state change and no ack or tx_start disturbance.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ requesters using round-robin
// arbitration. A winning requester gets a one-cycle ack, and its byte is
// latched into tx_data. The block then pulses tx_start and waits for
// tx_done. If tx_done does not arrive within TIMEOUT cycles, the transfer
// is abandoned and the sticky timeout_err flag is set.
//
// Ports
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset
//   req          level request per requester, held until its ack
//   req_data     byte for requester k on bits [8k+7:8k]
//   tx_done      one-cycle pulse from the transmitter at end of stop bit
//   clr_err      synchronous clear of timeout_err
//   ack          one-hot, one-cycle acceptance strobe
//   tx_start     one-cycle pulse to start the transmitter
//   tx_data      registered byte being transmitted
//   owner        index of the requester currently or last granted
//   busy         high whenever the FSM is not idle
//   timeout_err  sticky timeout flag
//
// State | meaning
// IDLE  | waiting for any request; winner is picked on the exit edge
// GRANT | ack[owner] high for one cycle
// START | tx_start high for one cycle; timeout counter cleared
// WAIT  | counting cycles until tx_done or timeout

module uart_tx_arbiter #(
    parameter int          NUM_REQ = 4,
    parameter logic [15:0] TIMEOUT = 16'd12000
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic                   tx_done,
    input  logic                   clr_err,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic [1:0]             owner,
    output logic                   busy,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  last_owner;
    logic [15:0] timer;
    logic [1:0]  winner;
    logic        found;
    logic [1:0]  cand;

    // Search starts one past the last owner and wraps, so the requester
    // served most recently always ranks last.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        cand   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_owner + 2'(i);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            owner       <= 2'd0;
            last_owner  <= 2'd3;
            tx_data     <= 8'h00;
            ack         <= '0;
            tx_start    <= 1'b0;
            timer       <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            ack      <= '0;
            tx_start <= 1'b0;
            // A timeout in the WAIT branch below overrides this clear.
            if (clr_err) begin
                timeout_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= GRANT;
                        owner   <= winner;
                        tx_data <= req_data[{winner, 3'b000} +: 8];
                        ack     <= NUM_REQ'(1) << winner;
                    end
                end
                GRANT: begin
                    state    <= START;
                    tx_start <= 1'b1;
                end
                START: begin
                    state <= WAIT;
                    timer <= 16'd0;
                end
                WAIT: begin
                    if (tx_done) begin
                        state      <= IDLE;
                        last_owner <= owner;
                    end else if (timer == TIMEOUT - 16'd1) begin
                        state       <= IDLE;
                        last_owner  <= owner;
                        timeout_err <= 1'b1;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        tx_done;
    logic        clr_err;

    logic [3:0]  ack,   ack_t;
    logic        tx_start, tx_start_t;
    logic [7:0]  tx_data, tx_data_t;
    logic [1:0]  owner, owner_t;
    logic        busy, busy_t;
    logic        timeout_err, timeout_err_t;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Main instance with the default timeout (long transfers never expire).
    uart_tx_arbiter dut (
        .clk(clk), .resetn(resetn), .req(req), .req_data(req_data),
        .tx_done(tx_done), .clr_err(clr_err), .ack(ack), .tx_start(tx_start),
        .tx_data(tx_data), .owner(owner), .busy(busy), .timeout_err(timeout_err)
    );

    // Short-timeout instance sharing the same inputs.
    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT(16'd20)) dut_to (
        .clk(clk), .resetn(resetn), .req(req), .req_data(req_data),
        .tx_done(tx_done), .clr_err(clr_err), .ack(ack_t), .tx_start(tx_start_t),
        .tx_data(tx_data_t), .owner(owner_t), .busy(busy_t), .timeout_err(timeout_err_t)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        req      = 4'b0;
        tx_done  = 1'b0;
        clr_err  = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    // Wait for the next grant on the main instance, check it, drop the
    // granted request and complete the transfer with tx_done.
    task automatic serve(input int exp_idx, input logic [7:0] exp_byte);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (ack != 4'b0) got = 1'b1;
        end
        chk("serve_ack_seen", 32'(got), 32'd1);
        chk("serve_ack", 32'(ack), 32'(4'b0001 << exp_idx));
        chk("serve_owner", 32'(owner), 32'(exp_idx));
        chk("serve_data", 32'(tx_data), 32'(exp_byte));
        req = req & ~ack;
        tick();
        chk("serve_start", 32'(tx_start), 32'd1);
        repeat (3) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("serve_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn   = 1'b0;
        req      = 4'b0;
        req_data = 32'h0;
        tx_done  = 1'b0;
        clr_err  = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        do_reset();

        // Single request, tx_done 50 cycles after tx_start.
        req_data = 32'h00A5_0000;
        req      = 4'b0100;
        tick();
        chk("single_ack", 32'(ack), 32'(4'b0100));
        chk("single_owner", 32'(owner), 32'd2);
        chk("single_data", 32'(tx_data), 32'hA5);
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_nostart", 32'(tx_start), 32'd0);
        req = 4'b0;
        tick();
        chk("single_start", 32'(tx_start), 32'd1);
        chk("single_ack_off", 32'(ack), 32'd0);
        repeat (50) tick();
        tx_done = 1'b1;
        chk("single_busy_wait", 32'(busy), 32'd1);
        tick();
        tx_done = 1'b0;
        chk("single_idle", 32'(busy), 32'd0);
        chk("single_err", 32'(timeout_err), 32'd0);
        tick();
        chk("single_no_restart", 32'(tx_start), 32'd0);

        // Fairness: all four requesting, then 0 and 2 again.
        do_reset();
        req_data = 32'h4433_2211;
        req      = 4'b1111;
        serve(0, 8'h11);
        serve(1, 8'h22);
        serve(2, 8'h33);
        serve(3, 8'h44);
        req = 4'b0101;
        serve(0, 8'h11);
        serve(2, 8'h33);

        // Timeout on the short-timeout instance: WAIT lasts 20 cycles.
        do_reset();
        req_data = 32'h0000_005A;
        req      = 4'b0001;
        tick();
        chk("to_ack", 32'(ack_t), 32'd1);
        chk("to_data", 32'(tx_data_t), 32'h5A);
        req = 4'b0;
        tick();
        chk("to_start", 32'(tx_start_t), 32'd1);
        repeat (20) tick();
        chk("to_last_wait", 32'(busy_t), 32'd1);
        chk("to_err_before", 32'(timeout_err_t), 32'd0);
        tick();
        chk("to_idle", 32'(busy_t), 32'd0);
        chk("to_err_set", 32'(timeout_err_t), 32'd1);
        repeat (3) tick();
        chk("to_err_sticky", 32'(timeout_err_t), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("to_err_clr", 32'(timeout_err_t), 32'd0);
        req_data = 32'h0000_C300;
        req      = 4'b0010;
        tick();
        chk("to_next_ack", 32'(ack_t), 32'(4'b0010));
        chk("to_next_data", 32'(tx_data_t), 32'hC3);
        req = 4'b0;
        tick();
        chk("to_next_start", 32'(tx_start_t), 32'd1);
        repeat (5) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("to_next_idle", 32'(busy_t), 32'd0);
        chk("to_next_err", 32'(timeout_err_t), 32'd0);

        // tx_done on the exact timeout cycle: done wins.
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0;
        tick();
        repeat (20) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("sim_done_idle", 32'(busy_t), 32'd0);
        chk("sim_done_noerr", 32'(timeout_err_t), 32'd0);
        // clr_err on the timeout cycle: set wins.
        req = 4'b0010;
        tick();
        req = 4'b0;
        tick();
        repeat (20) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("sim_clr_idle", 32'(busy_t), 32'd0);
        chk("sim_clr_err", 32'(timeout_err_t), 32'd1);

        // Reset during WAIT.
        do_reset();
        req_data = 32'h0077_0000;
        req      = 4'b0100;
        tick();
        req = 4'b0;
        tick();
        repeat (25) tick();
        chk("rw_busy_before", 32'(busy), 32'd1);
        chk("rw_to_err_before", 32'(timeout_err_t), 32'd1);
        resetn = 1'b0;
        #1;
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_ack", 32'(ack), 32'd0);
        chk("rw_start", 32'(tx_start), 32'd0);
        chk("rw_owner", 32'(owner), 32'd0);
        chk("rw_data", 32'(tx_data), 32'd0);
        chk("rw_err_t", 32'(timeout_err_t), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rw_hold_start", 32'(tx_start), 32'd0);
        end
        resetn   = 1'b1;
        req_data = 32'hE100_0000;
        req      = 4'b1000;
        tick();
        chk("rw_ack3", 32'(ack), 32'(4'b1000));
        chk("rw_owner3", 32'(owner), 32'd3);
        chk("rw_data3", 32'(tx_data), 32'hE1);
        req = 4'b0;
        tick();
        chk("rw_start3", 32'(tx_start), 32'd1);
        repeat (4) tick();
        resetn = 1'b0;
        tick();
        resetn   = 1'b1;
        req_data = 32'hE100_0012;
        req      = 4'b1001;
        tick();
        chk("rw_prio0", 32'(ack), 32'(4'b0001));
        req = 4'b1000;
        tick();
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        req = 4'b0;

        // Stray tx_done in IDLE and GRANT.
        do_reset();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("stray_idle_busy", 32'(busy), 32'd0);
        chk("stray_idle_ack", 32'(ack), 32'd0);
        chk("stray_idle_start", 32'(tx_start), 32'd0);
        req_data = 32'h0000_9900;
        req      = 4'b0010;
        tick();
        chk("stray_grant_ack", 32'(ack), 32'(4'b0010));
        req     = 4'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("stray_start", 32'(tx_start), 32'd1);
        chk("stray_ack_off", 32'(ack), 32'd0);
        tick();
        chk("stray_wait1", 32'(busy), 32'd1);
        tick();
        chk("stray_wait2", 32'(busy), 32'd1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("stray_done", 32'(busy), 32'd0);
        chk("stray_data", 32'(tx_data), 32'h99);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
